// File: rtl/text_console_writer_if.sv
// Byte-stream input and Avalon-MM VRAM write port of the text console writer.
interface text_console_writer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  attr;
  logic [11:0] m_addr;
  logic        m_write;
  logic [3:0]  m_byte_en;
  logic [31:0] m_writedata;
  logic        m_waitrequest;

  modport master (
    input  in_data, in_valid, attr, m_waitrequest,
    output in_ready, m_addr, m_write, m_byte_en, m_writedata
  );

  modport slave (
    output in_data, in_valid, attr, m_waitrequest,
    input  in_ready, m_addr, m_write, m_byte_en, m_writedata
  );
endinterface

// File: rtl/text_console_writer.sv
// Turns an ASCII byte stream into VGA text-mode VRAM writes, handling cursor,
// line wrap, row clearing and full-screen clear.
module text_console_writer #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 30,
  parameter int unsigned WPR  = COLS / 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  text_console_writer_if.master bus,
  output logic [6:0]            cursor_col,
  output logic [4:0]            cursor_row,
  output logic                  busy
);

  localparam int unsigned Words    = ROWS * WPR;
  localparam logic [11:0] LastWord = 12'(Words - 1);
  localparam logic [6:0]  LastCol  = 7'(COLS - 1);
  localparam logic [4:0]  LastRow  = 5'(ROWS - 1);

  typedef enum logic [2:0] {StRstClr, StIdle, StWrChar, StClrRow, StClrAll} state_e;

  state_e      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [7:0]  attr_q, attr_d;
  logic [11:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  logic        accept, wr_done, clr_last, printable;
  logic [4:0]  row_nxt;
  logic [11:0] row_base, nxt_base, clr_end;
  logic [15:0] in_cell, in_blank, q_blank;

  assign bus.in_ready = (state_q == StIdle);
  assign accept       = bus.in_ready & bus.in_valid;
  assign wr_done      = write_q & ~bus.m_waitrequest;
  assign row_nxt      = (row_q == LastRow) ? 5'd0 : row_q + 5'd1;
  assign row_base     = 12'(row_q) * 12'(WPR);
  assign nxt_base     = 12'(row_nxt) * 12'(WPR);
  // A row clear ends on the last word of the (already advanced) cursor row.
  assign clr_end      = (state_q == StClrRow) ? row_base + 12'(WPR - 1) : LastWord;
  assign clr_last     = (addr_q == clr_end);
  assign printable    = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);
  assign in_cell      = {1'b0, bus.in_data[6:0], bus.attr};
  assign in_blank     = {8'h20, bus.attr};
  assign q_blank      = {8'h20, attr_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StRstClr;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRstClr, StClrAll, StClrRow: if (wr_done && clr_last) state_d = StIdle;
      StIdle: begin
        if (accept) begin
          if (printable)                  state_d = StWrChar;
          else if (bus.in_data == 8'h0A)  state_d = StClrRow;
          else if (bus.in_data == 8'h0C)  state_d = StClrAll;
        end
      end
      StWrChar: if (wr_done) state_d = (col_q == LastCol) ? StClrRow : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    attr_d  = attr_q;
    addr_d  = addr_q;
    write_d = write_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StRstClr: begin
        if (!write_q) begin
          // First cycle after reset release: launch word 0.
          write_d = 1'b1;
          addr_d  = 12'd0;
          be_d    = 4'hF;
          wdata_d = 32'h2000_2000;
        end else if (wr_done) begin
          if (clr_last) write_d = 1'b0;
          else          addr_d  = addr_q + 12'd1;
        end
      end
      StClrAll, StClrRow: begin
        if (wr_done) begin
          if (clr_last) write_d = 1'b0;
          else          addr_d  = addr_q + 12'd1;
        end
      end
      StIdle: begin
        if (accept) begin
          attr_d = bus.attr;
          if (printable) begin
            write_d = 1'b1;
            addr_d  = row_base + 12'(col_q[6:1]);
            be_d    = col_q[0] ? 4'b1100 : 4'b0011;
            wdata_d = {in_cell, in_cell};
          end else if (bus.in_data == 8'h0A) begin
            col_d   = 7'd0;
            row_d   = row_nxt;
            write_d = 1'b1;
            addr_d  = nxt_base;
            be_d    = 4'hF;
            wdata_d = {in_blank, in_blank};
          end else if (bus.in_data == 8'h0D) begin
            col_d = 7'd0;
          end else if (bus.in_data == 8'h08) begin
            if (col_q != 7'd0) col_d = col_q - 7'd1;
          end else if (bus.in_data == 8'h0C) begin
            col_d   = 7'd0;
            row_d   = 5'd0;
            write_d = 1'b1;
            addr_d  = 12'd0;
            be_d    = 4'hF;
            wdata_d = {in_blank, in_blank};
          end
        end
      end
      StWrChar: begin
        if (wr_done) begin
          if (col_q != LastCol) begin
            col_d   = col_q + 7'd1;
            write_d = 1'b0;
          end else begin
            col_d   = 7'd0;
            row_d   = row_nxt;
            addr_d  = nxt_base;
            be_d    = 4'hF;
            wdata_d = {q_blank, q_blank};
          end
        end
      end
      default: write_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      attr_q  <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      attr_q  <= attr_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.m_addr      = addr_q;
  assign bus.m_write     = write_q;
  assign bus.m_byte_en   = be_q;
  assign bus.m_writedata = wdata_q;
  assign cursor_col      = col_q;
  assign cursor_row      = row_q;
  assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_text_console_writer.sv
// Directed self-checking bench for text_console_writer (80x30 text screen).
module tb_text_console_writer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;

  text_console_writer_if bus ();

  text_console_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int oob   = 0;
  logic [11:0] wa[$];
  logic [3:0]  wb[$];
  logic [31:0] wd[$];

  // A write is recorded when it will complete on the coming rising edge.
  always @(negedge clk) begin
    if (rst_n && bus.m_write && !bus.m_waitrequest) begin
      wa.push_back(bus.m_addr);
      wb.push_back(bus.m_byte_en);
      wd.push_back(bus.m_writedata);
      if (bus.m_addr >= 12'd1200) oob++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wb.delete();
    wd.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < budget);
    if (!bus.in_ready) check("idle_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] a);
    wait_idle(3000);
    bus.in_data  = b;
    bus.attr     = a;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Checks n logged full-word clear writes starting at index first, address base.
  task automatic check_clear(input string tag, input int first, input int base, input int n,
                             input logic [31:0] data);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (first + i >= wa.size()) bad++;
      else if (wa[first+i] !== 12'(base + i) || wd[first+i] !== data || wb[first+i] !== 4'hF)
        bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    int bad;
    logic [7:0] ch;
    rst_n             = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_data       = 8'h00;
    bus.attr          = 8'h00;
    bus.m_waitrequest = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_m_write", 32'(bus.m_write), 32'd0);
    check("rst_m_addr", 32'(bus.m_addr), 32'd0);
    check("rst_m_be", 32'(bus.m_byte_en), 32'd0);
    check("rst_m_wdata", bus.m_writedata, 32'd0);
    check("rst_cursor", {cursor_row, cursor_col}, 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_first_write", 32'(bus.m_write), 32'd1);
    wait_idle(1300);
    check("rst_clr_count", 32'(wa.size()), 32'd1200);
    check_clear("rst_clr_words", 0, 0, 1200, 32'h2000_2000);
    check("rst_done_cursor", {cursor_row, cursor_col}, 32'd0);
    check("rst_done_busy", 32'(busy), 32'd0);

    // Two characters into word 0, with 2-cycle throughput timing
    clear_log();
    wait_idle(10);
    bus.in_data = 8'h41; bus.attr = 8'h1E; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("chr_write_next", 32'(bus.m_write), 32'd1);
    check("chr_ready_low", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("chr_ready_back", 32'(bus.in_ready), 32'd1);
    send_byte(8'h42, 8'h07);
    wait_idle(10);
    check("chr_count", 32'(wa.size()), 32'd2);
    check("chr0_addr", 32'(wa[0]), 32'd0);
    check("chr0_be", 32'(wb[0]), 32'h3);
    check("chr0_data", wd[0], 32'h411E_411E);
    check("chr1_addr", 32'(wa[1]), 32'd0);
    check("chr1_be", 32'(wb[1]), 32'hC);
    check("chr1_data", wd[1], 32'h4207_4207);
    check("chr_cursor", {cursor_row, cursor_col}, {20'd0, 5'd0, 7'd2});

    // CR: no write, ready again next cycle
    clear_log();
    send_byte(8'h0D, 8'h07);
    @(negedge clk);
    check("cr_ready", 32'(bus.in_ready), 32'd1);
    check("cr_cursor", {cursor_row, cursor_col}, 32'd0);

    // 80 characters fill row 0, then row 1 is cleared
    for (int i = 0; i < 80; i++) send_byte(8'h30 + 8'(i % 10), 8'h07);
    wait_idle(100);
    check("row_count", 32'(wa.size()), 32'd120);
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      ch = 8'h30 + 8'(i % 10);
      if (wa[i] !== 12'(i / 2) || wb[i] !== ((i % 2) ? 4'hC : 4'h3) ||
          wd[i] !== {1'b0, ch[6:0], 8'h07, 1'b0, ch[6:0], 8'h07})
        bad++;
    end
    check("row_chars", 32'(bad), 32'd0);
    check("row_last_addr", 32'(wa[79]), 32'd39);
    check("row_last_be", 32'(wb[79]), 32'hC);
    check_clear("row_wrap_clear", 80, 40, 40, 32'h2007_2007);
    check("row_cursor", {cursor_row, cursor_col}, {20'd0, 5'd1, 7'd0});

    // Move to (5,29), then LF wraps to row 0
    for (int i = 0; i < 28; i++) send_byte(8'h0A, 8'h07);
    for (int i = 0; i < 5; i++) send_byte(8'h2E, 8'h07);
    wait_idle(100);
    check("bottom_cursor", {cursor_row, cursor_col}, {20'd0, 5'd29, 7'd5});
    check("bottom_last_addr", 32'(wa[wa.size()-1]), 32'(29 * 40 + 2));
    clear_log();
    send_byte(8'h0A, 8'h30);
    wait_idle(100);
    check("lf_wrap_count", 32'(wa.size()), 32'd40);
    check_clear("lf_wrap_clear", 0, 0, 40, 32'h2030_2030);
    check("lf_wrap_cursor", {cursor_row, cursor_col}, 32'd0);
    clear_log();
    send_byte(8'h0D, 8'h30);
    send_byte(8'h08, 8'h30);
    wait_idle(10);
    check("cr_bs_nowrite", 32'(wa.size()), 32'd0);
    check("cr_bs_cursor", {cursor_row, cursor_col}, 32'd0);
    send_byte(8'h5A, 8'h30);
    send_byte(8'h08, 8'h30);
    wait_idle(10);
    check("bs_no_erase", 32'(wa.size()), 32'd1);
    check("bs_cursor", {cursor_row, cursor_col}, 32'd0);
    send_byte(8'h01, 8'h30);
    wait_idle(10);
    check("ignored_nowrite", 32'(wa.size()), 32'd1);
    check("ignored_cursor", {cursor_row, cursor_col}, 32'd0);

    // Stall a character write for 3 cycles
    clear_log();
    wait_idle(10);
    bus.m_waitrequest = 1'b1;
    bus.in_data = 8'h51; bus.attr = 8'h0F; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) bus.m_waitrequest = 1'b0;
      if (bus.m_write !== 1'b1 || bus.m_addr !== 12'd0 || bus.m_byte_en !== 4'h3 ||
          bus.m_writedata !== 32'h510F_510F || bus.in_ready !== 1'b0)
        bad++;
    end
    check("stall_stable", 32'(bad), 32'd0);
    @(negedge clk);
    check("stall_write_done", 32'(bus.m_write), 32'd0);
    check("stall_ready", 32'(bus.in_ready), 32'd1);
    check("stall_one_write", 32'(wa.size()), 32'd1);
    check("stall_cursor", {cursor_row, cursor_col}, {20'd0, 5'd0, 7'd1});

    // Form feed clears the whole screen
    clear_log();
    send_byte(8'h0C, 8'h12);
    @(negedge clk);
    check("ff_cursor", {cursor_row, cursor_col}, 32'd0);
    wait_idle(1300);
    check("ff_count", 32'(wa.size()), 32'd1200);
    check_clear("ff_words", 0, 0, 1200, 32'h2012_2012);

    // Reset in the middle of a full clear
    send_byte(8'h41, 8'h12);
    clear_log();
    send_byte(8'h0C, 8'h12);
    begin
      int n = 0;
      while (wa.size() < 500 && n < 2000) begin
        @(negedge clk);
        n++;
      end
    end
    check("mid_reached_500", 32'(wa.size()), 32'd500);
    check("mid_write_on", 32'(bus.m_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_write", 32'(bus.m_write), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd1);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    clear_log();
    rst_n = 1'b1;
    wait_idle(1300);
    check("mid_restart_count", 32'(wa.size()), 32'd1200);
    check_clear("mid_restart_words", 0, 0, 1200, 32'h2000_2000);
    check("mid_restart_cursor", {cursor_row, cursor_col}, 32'd0);
    check("addr_in_range", 32'(oob), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/text_console_writer.md
# text_console_writer

Hardware text console that turns a byte stream of ASCII characters into VRAM writes for the VGA text-mode display. It sits directly upstream of the VGA text Avalon slave. It drives that slave's VRAM port as an Avalon-MM write-only master, and it tracks the cursor, line wrap, row clearing and full-screen clear in hardware, so software or a UART only has to push bytes.

## Interface
Parameters:
- COLS, 80, characters per row. Must be even.
- ROWS, 30, character rows.
- WPR, COLS/2, 32-bit VRAM words per row (two character cells per word).

Ports:
- CLK  in  1  system clock (50 MHz); shared with the VGA slave.
- RESET  in  1  asynchronous, active-low reset.
- IN_DATA  in  8  ASCII byte.
- IN_VALID  in  1  IN_DATA valid.
- IN_READY  out  1  block accepts a byte; transfer occurs when IN_VALID and IN_READY are both high.
- ATTR  in  8  colour attribute {fg palette idx[7:4], bg palette idx[3:0]}; sampled on byte acceptance.
- M_ADDR  out  12  VRAM word address, 0..ROWS*WPR-1.
- M_WRITE  out  1  Avalon write request.
- M_BYTE_EN  out  4  byte enables.
- M_WRITEDATA  out  32  write data.
- M_WAITREQUEST  in  1  slave stall.
- CURSOR_COL  out  7  current column, 0..COLS-1.
- CURSOR_ROW  out  5  current row, 0..ROWS-1.
- BUSY  out  1  high in any state other than IDLE.

## Operation
- Cell format is 16 bits: {inv=0, code[6:0], ATTR[7:0]}.
- The cell at (row, col) lives in word row*WPR + col/2:
  - even col: bits [15:0], M_BYTE_EN=4'b0011
  - odd col: bits [31:16], M_BYTE_EN=4'b1100
- For single-cell writes, M_WRITEDATA carries the cell in both halves.
- The blank cell is {0, 7'h20, attr}. Clear writes use word {blank, blank} with M_BYTE_EN=4'b1111.
- FSM states: RST_CLR, IDLE, WR_CHAR, CLR_ROW, CLR_ALL.
- RST_CLR: entered on reset release. Writes words 0..ROWS*WPR-1 with attr 8'h00 (word 0x2000_2000). Exits to IDLE with the cursor at (0,0).
- IDLE: IN_READY=1. On acceptance, ATTR is latched and the byte is decoded:
  - 0x20..0x7E: go to WR_CHAR.
  - 0x0A (LF): col<=0; do a row advance.
  - 0x0D (CR): col<=0; stay in IDLE.
  - 0x08 (BS): col<=col-1 if col>0, else no change; the cell is not erased; stay in IDLE.
  - 0x0C (FF): cursor<=(0,0); go to CLR_ALL with the latched attr.
  - Any other byte: consumed and ignored.
- WR_CHAR: writes the cell at the cursor.
  - On completion, if col<COLS-1: col<=col+1 and return to IDLE.
  - Otherwise col<=0 and do a row advance.
- Row advance: row<=(row==ROWS-1)?0:row+1. Then go to CLR_ROW, which writes the WPR words of the new row with the latched attr and then returns to IDLE. There is no scrolling; the screen wraps to row 0.
- CLR_ALL: writes words 0..ROWS*WPR-1 in ascending order, then returns to IDLE.
- The block never addresses ≥ ROWS*WPR. The palette region is never touched.

## Timing
- Reset values:
  - IN_READY=0, M_WRITE=0, M_ADDR=0, M_BYTE_EN=0, M_WRITEDATA=0
  - CURSOR_COL=0, CURSOR_ROW=0
  - BUSY=1 (state RST_CLR)
- The first clear write is asserted in the first cycle after RESET deasserts.
- All master outputs are registered. A write completes on a rising edge where M_WRITE=1 and M_WAITREQUEST=0.
- While M_WAITREQUEST=1, M_ADDR, M_BYTE_EN and M_WRITEDATA stay stable and M_WRITE stays high.
- Printable byte accepted at edge N:
  - M_WRITE is high in cycle N+1.
  - With no stall, the write completes at edge N+1.
  - IN_READY is high in cycle N+2, giving 1 char per 2 cycles.
- Clears issue back-to-back, one word per cycle with no stall. CLR_ROW takes WPR cycles; clears take ROWS*WPR cycles.
- CR, BS and ignored bytes: IN_READY remains high the next cycle, giving 1 byte per cycle.
- The cursor outputs update on the edge that completes the state's final write, or on acceptance for CR, LF and BS.
- IN_READY=0 whenever state≠IDLE; IN_VALID held during BUSY is not consumed.
- Reset asserted mid-transfer: M_WRITE drops asynchronously, the cursor goes to (0,0), and the full RST_CLR restarts on release.

## Test plan
- Reset release, M_WAITREQUEST=0 → exactly 1200 writes, addresses 0..1199, data 0x2000_2000, BE 4'hF; then IN_READY=1, cursor (0,0).
- Accept 0x41 with ATTR=0x1E, then 0x42 with ATTR=0x07:
  - first write: addr 0, BE 4'b0011, data 0x411E_411E
  - second write: addr 0, BE 4'b1100, data 0x4207_4207
  - cursor ends at (2,0).
- Send 80 printable bytes from (0,0) → last char written at addr 39, BE 4'b1100; then 40 clear writes at addresses 40..79; cursor (0,1).
- At cursor (5,29), send 0x0A with ATTR=0x30 → 40 writes at addresses 0..39, data 0x2030_2030; cursor (0,0). Then send 0x0D and 0x08 at col 0 → no writes, cursor stays (0,0).
- Hold M_WAITREQUEST=1 for 3 cycles on a char write → M_WRITE, M_ADDR and data are stable for 4 cycles; exactly one write completes; IN_READY=0 throughout.
- Send 0x0C with ATTR=0x12 → addresses 0..1199, data 0x2012_2012. Assert RESET at word 500 → M_WRITE=0 immediately; after release the clear restarts at addr 0 with 0x2000_2000.
